async_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_mem.sv | 37 +++
 rtl/async_fifo.sv | 72 +++++++
 tb/tb_async_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and word type for the byte FIFO and its storage.
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 16;

  typedef logic [DATA_W_DEFAULT-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read
// port. The read-port output register doubles as the FIFO's dout register,
// so it is the only storage element cleared by reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: contents are never reset and are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: output register updates only on an accepted read, else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/async_fifo.sv
// Single-clock byte FIFO with registered read data. Pointers carry one extra
// wrap bit so that full and empty are told apart without an occupancy counter.
//
// Handshake: a write is taken on a rising edge when wr_en && !full, a read
// when rd_en && !empty; both flags reflect the pointers before that edge, so
// an enable presented against a set flag is dropped with no side effect, and
// dout changes only on the edge that takes a read.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [ADDR_W:0] ptr_t;

  ptr_t wp;
  ptr_t rp;
  logic wr_acc;
  logic rd_acc;

  // Flags come straight from registered pointers; no input reaches an output.
  assign empty  = (wp == rp);
  assign full   = (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]) && (wp[ADDR_W] != rp[ADDR_W]);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Write pointer: advances on each accepted write, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
    end else if (wr_acc) begin
      wp <= wp + ptr_t'(1);
    end
  end

  // Read pointer: advances on each accepted read, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp <= '0;
    end else if (rd_acc) begin
      rp <= rp + ptr_t'(1);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wp[ADDR_W-1:0]),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rp[ADDR_W-1:0]),
    .rdata (dout)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: directed driver tasks, a reference queue model that
// predicts accepted reads into a scoreboard, and a monitor that checks dout
// and flags after every clock edge.
module tb_async_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic  clk;
  logic  rst_n;
  logic  wr_en;
  data_t din;
  logic  rd_en;
  data_t dout;
  logic  full;
  logic  empty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  async_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] model_q[$];   // words the FIFO should currently hold
  logic [7:0] exp_q[$];     // expected dout values, one per accepted read
  logic [7:0] last_exp;
  logic       exp_rd;
  logic       exp_empty;
  logic       exp_full;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_q.delete();
    exp_q.delete();
    last_exp  = 8'h00;
    exp_rd    = 1'b0;
    exp_empty = 1'b1;
    exp_full  = 1'b0;
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic acc_r;
    logic acc_w;
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    acc_r = r && (model_q.size() > 0);
    acc_w = w && (model_q.size() < DEPTH);
    if (acc_r) exp_q.push_back(model_q.pop_front());
    if (acc_w) model_q.push_back(d);
    exp_rd    = acc_r;
    exp_empty = (model_q.size() == 0);
    exp_full  = (model_q.size() == DEPTH);
    @(posedge clk);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  // ---------------- monitor ----------------
  logic mon_rd;
  logic mon_e;
  logic mon_f;
  logic mon_rst;

  // Snapshot the prediction at the edge, then check settled outputs shortly after.
  always @(posedge clk) begin
    mon_rd  = exp_rd;
    mon_e   = exp_empty;
    mon_f   = exp_full;
    mon_rst = rst_n;
    #2;
    if (mon_rst && rst_n) begin
      if (mon_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underrun: read predicted with empty scoreboard at %0t", $time);
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
      chk("dout", {24'h0, dout}, {24'h0, last_exp});
      chk("empty", {31'h0, empty}, {31'h0, mon_e});
      chk("full", {31'h0, full}, {31'h0, mon_f});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ordered transfer, then extra reads on empty keep dout at 0xEA.
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hAB, 1'b0);
    step(1'b1, 8'h2A, 1'b0);
    step(1'b1, 8'hEA, 1'b0);
    reads(4);
    reads(2);

    // Fill to full, overflow write dropped, drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    reads(DEPTH);

    // Underflow: reads on empty do nothing; next word comes back intact.
    reads(2);
    step(1'b1, 8'h5C, 1'b0);
    reads(1);

    // Simultaneous traffic at occupancy 3 across the pointer wrap.
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h13 + i), 1'b1);
    reads(3);

    // Full with both enables: only the read happens.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    reads(DEPTH - 1);
    // Empty with both enables: only the write happens, dout holds 0x8F.
    step(1'b1, 8'h77, 1'b1);
    reads(1);

    // Asynchronous reset in the middle of a full buffer.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    reads(1);
    step(1'b1, 8'h40, 1'b0);
    #3;
    apply_reset();
    #1;
    chk("mid_rst_empty", {31'h0, empty}, 32'h1);
    chk("mid_rst_full", {31'h0, full}, 32'h0);
    chk("mid_rst_dout", {24'h0, dout}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h99, 1'b0);
    reads(1);

    repeat (3) step(1'b0, 8'h00, 1'b0);
    #3;
    chk("sb_drain", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
